// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_controller
//  Brief    : 4-digit FND refresh scheduler with per-slot blanking guard,
//             per-frame BCD snapshot and optional leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_controller #(
   parameter int CLK_DIV      = 100_000,
   parameter int BLANK_CYCLES = 1_000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_Run,
   input  logic        i_LZB_En,
   input  logic [15:0] i_BCD_Data,
   output logic        o_Decoder_En,
   output logic [1:0]  o_DigitSelect,
   output logic [3:0]  o_BCD,
   output logic        o_Frame_Tick
);

   localparam int c_CNT_W       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int c_SHOW_CYCLES = CLK_DIV - BLANK_CYCLES;
   localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(c_SHOW_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [1:0]         r_digit;
   logic [15:0]        r_snap;

   logic               w_lzb_blank;
   logic [1:0]         w_digit_nxt;
   logic               w_wrap;
   logic [3:0]         w_bcd_nxt;

   function automatic logic [3:0] f_nibble(input logic [15:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    f_nibble = word[3:0];
         2'd1:    f_nibble = word[7:4];
         2'd2:    f_nibble = word[11:8];
         default: f_nibble = word[15:12];
      endcase
   endfunction

   // A digit is dark when it and every more significant nibble is zero.
   always_comb begin
      w_lzb_blank = 1'b0;
      case (r_digit)
         2'd1:    w_lzb_blank = i_LZB_En && (r_snap[15:4]  == 12'd0);
         2'd2:    w_lzb_blank = i_LZB_En && (r_snap[15:8]  == 8'd0);
         2'd3:    w_lzb_blank = i_LZB_En && (r_snap[15:12] == 4'd0);
         default: w_lzb_blank = 1'b0;
      endcase
   end

   assign w_digit_nxt = r_digit + 2'd1;
   assign w_wrap      = (r_digit == 2'd3);
   // On wrap the new snapshot is loaded in the same edge, so read the live word.
   assign w_bcd_nxt   = w_wrap ? i_BCD_Data[3:0] : f_nibble(r_snap, w_digit_nxt);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_digit       <= 2'd0;
         r_snap        <= 16'd0;
         o_Decoder_En  <= 1'b0;
         o_DigitSelect <= 2'd0;
         o_BCD         <= 4'd0;
         o_Frame_Tick  <= 1'b0;
      end else if (!i_Run) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_digit       <= 2'd0;
         o_Decoder_En  <= 1'b0;
         o_DigitSelect <= 2'd0;
         o_BCD         <= 4'd0;
         o_Frame_Tick  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state       <= ST_BLANK;
               r_cnt         <= '0;
               r_digit       <= 2'd0;
               r_snap        <= i_BCD_Data;
               o_Decoder_En  <= 1'b0;
               o_DigitSelect <= 2'd0;
               o_BCD         <= i_BCD_Data[3:0];
               o_Frame_Tick  <= 1'b1;
            end
            ST_BLANK: begin
               o_Frame_Tick <= 1'b0;
               if (r_cnt == c_BLANK_LAST) begin
                  r_state      <= ST_SHOW;
                  r_cnt        <= '0;
                  o_Decoder_En <= ~w_lzb_blank;
               end else begin
                  r_cnt        <= r_cnt + 1'b1;
                  o_Decoder_En <= 1'b0;
               end
            end
            ST_SHOW: begin
               if (r_cnt == c_SHOW_LAST) begin
                  r_state       <= ST_BLANK;
                  r_cnt         <= '0;
                  r_digit       <= w_digit_nxt;
                  o_Decoder_En  <= 1'b0;
                  o_DigitSelect <= w_digit_nxt;
                  o_BCD         <= w_bcd_nxt;
                  o_Frame_Tick  <= w_wrap;
                  if (w_wrap) begin
                     r_snap <= i_BCD_Data;
                  end
               end else begin
                  r_cnt        <= r_cnt + 1'b1;
                  o_Decoder_En <= ~w_lzb_blank;
                  o_Frame_Tick <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_cnt         <= '0;
               r_digit       <= 2'd0;
               o_Decoder_En  <= 1'b0;
               o_DigitSelect <= 2'd0;
               o_BCD         <= 4'd0;
               o_Frame_Tick  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_controller
//  Brief    : Directed self-checking bench for fnd_scan_controller (8/2 slot).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

   localparam int c_CLK_DIV = 8;
   localparam int c_BLANK   = 2;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        lzb_en;
   logic [15:0] bcd_data;
   logic        dec_en;
   logic [1:0]  dig_sel;
   logic [3:0]  bcd;
   logic        frame_tick;

   int n_vec = 0;
   int n_err = 0;

   fnd_scan_controller #(
      .CLK_DIV      (c_CLK_DIV),
      .BLANK_CYCLES (c_BLANK)
   ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_Run         (run),
      .i_LZB_En      (lzb_en),
      .i_BCD_Data    (bcd_data),
      .o_Decoder_En  (dec_en),
      .o_DigitSelect (dig_sel),
      .o_BCD         (bcd),
      .o_Frame_Tick  (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dark(input string tag);
      check({tag, " en"},   {15'd0, dec_en},     16'd0);
      check({tag, " sel"},  {14'd0, dig_sel},    16'd0);
      check({tag, " bcd"},  {12'd0, bcd},        16'd0);
      check({tag, " tick"}, {15'd0, frame_tick}, 16'd0);
   endtask

   // Checks one full frame starting on its first BLANK cycle; ends on the next frame's first cycle.
   task automatic check_frame(input logic [15:0] exp_bcd, input logic [3:0] exp_en,
                              input int chg_slot, input logic [15:0] chg_data, input logic chg_lzb);
      logic [15:0] eb;
      logic [3:0]  ee;
      eb = exp_bcd;
      ee = exp_en;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < c_CLK_DIV; c++) begin
            check($sformatf("d%0d c%0d sel", d, c), {14'd0, dig_sel}, 16'(d));
            check($sformatf("d%0d c%0d bcd", d, c), {12'd0, bcd}, {12'd0, eb[4*d +: 4]});
            check($sformatf("d%0d c%0d en", d, c), {15'd0, dec_en},
                  (c >= c_BLANK) ? {15'd0, ee[d]} : 16'd0);
            check($sformatf("d%0d c%0d tick", d, c), {15'd0, frame_tick},
                  (d == 0 && c == 0) ? 16'd1 : 16'd0);
            if (d * c_CLK_DIV + c == chg_slot) begin
               bcd_data = chg_data;
               lzb_en   = chg_lzb;
            end
            step();
         end
      end
   endtask

   // Select and BCD must hold while the decoder stays enabled.
   initial begin
      logic       prev_en;
      logic [1:0] prev_sel;
      logic [3:0] prev_bcd;
      prev_en  = 1'b0;
      prev_sel = 2'd0;
      prev_bcd = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_en && dec_en) begin
            check("stable sel/bcd", {10'd0, dig_sel, bcd}, {10'd0, prev_sel, prev_bcd});
         end
         prev_en  = dec_en;
         prev_sel = dig_sel;
         prev_bcd = bcd;
      end
   end

   initial begin
      rst_n    = 1'b0;
      run      = 1'b0;
      lzb_en   = 1'b0;
      bcd_data = 16'h0000;
      step();
      step();
      check_dark("reset");

      // Reach SHOW, then assert reset between clock edges.
      rst_n    = 1'b1;
      run      = 1'b1;
      bcd_data = 16'h1234;
      step();
      check("start tick", {15'd0, frame_tick}, 16'd1);
      check("start bcd",  {12'd0, bcd},        16'd4);
      step();
      check("guard en", {15'd0, dec_en}, 16'd0);
      step();
      check("show en", {15'd0, dec_en}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_dark("async reset");
      run = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      check_dark("idle after release");
      step();
      check_dark("idle hold");

      // Plain scan, then LZB frames, then mid-frame data change.
      run = 1'b1;
      step();
      check_frame(16'h1234, 4'b1111, 0, 16'h1234, 1'b0);
      check_frame(16'h1234, 4'b1111, 0, 16'h0050, 1'b1);
      check_frame(16'h0050, 4'b0011, 0, 16'h0000, 1'b1);
      check_frame(16'h0000, 4'b0001, 31, 16'h1234, 1'b0);
      check_frame(16'h1234, 4'b1111, 12, 16'h5678, 1'b0);
      check_frame(16'h5678, 4'b1111, 0, 16'h5678, 1'b0);

      // Drop run during digit 2 SHOW.
      for (int i = 0; i < 19; i++) step();
      check("d2 show sel", {14'd0, dig_sel}, 16'd2);
      check("d2 show en",  {15'd0, dec_en},  16'd1);
      run = 1'b0;
      step();
      check_dark("run drop");
      step();
      check_dark("run low hold");
      run = 1'b1;
      step();
      check_frame(16'h5678, 4'b1111, 0, 16'h5678, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
